// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution sequencer.
package conv_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int LEN_W_DEF  = 6;
    localparam int MAX_LEN    = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        MAC,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/conv_mac.sv
// Unsigned multiply-accumulate with synchronous clear; wraps modulo 2^ACC_W.
module conv_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Linear convolution sequencer: walks i over outputs and j over Y taps,
// reading X/Y memories and writing one Z sample per output index.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  size_x,
    input  logic [LEN_W-1:0]  size_y,
    output logic [4:0]        memx_addr,
    input  logic [DATA_W-1:0] memx_data,
    output logic [4:0]        memy_addr,
    input  logic [DATA_W-1:0] memy_data,
    output logic [5:0]        memz_addr,
    output logic [ACC_W-1:0]  memz_data,
    output logic              memz_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t     state;
    logic [5:0] i;
    logic [5:0] j;
    logic [5:0] sx;
    logic [5:0] sy;
    logic [5:0] nz_last;
    logic [5:0] j_nxt;
    logic [5:0] diff;
    logic [5:0] diff_nxt;
    logic       in_range;
    logic       legal;
    logic       mac_clear;
    logic       mac_en;

    assign j_nxt    = j + 6'd1;
    assign diff     = i - j;
    assign diff_nxt = i - j_nxt;
    // X index i-j must land inside 0..size_x-1 for the tap to count
    assign in_range = (i >= j) && (diff < sx);

    assign legal = (size_x != '0) && (size_y != '0)
                && (size_x <= LEN_W'(MAX_LEN))
                && (size_y <= LEN_W'(MAX_LEN));

    assign mac_clear = (state == CLEAR);
    assign mac_en    = (state == MAC) && in_range;

    conv_mac #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(mac_clear),
        .en   (mac_en),
        .a    (memx_data),
        .b    (memy_data),
        .acc  (memz_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            sx        <= '0;
            sy        <= '0;
            nz_last   <= '0;
            memx_addr <= '0;
            memy_addr <= '0;
            memz_addr <= '0;
            memz_we   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (legal) begin
                            err     <= 1'b0;
                            sx      <= size_x[5:0];
                            sy      <= size_y[5:0];
                            nz_last <= size_x[5:0] + size_y[5:0] - 6'd2;
                            i       <= '0;
                            state   <= CLEAR;
                        end else begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                CLEAR: begin
                    j         <= '0;
                    memx_addr <= i[4:0];
                    memy_addr <= '0;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    state <= MAC;
                end
                MAC: begin
                    j <= j_nxt;
                    if (j_nxt == sy) begin
                        memz_we   <= 1'b1;
                        memz_addr <= i;
                        state     <= WRITE;
                    end else begin
                        memx_addr <= diff_nxt[4:0];
                        memy_addr <= j_nxt[4:0];
                        state     <= ISSUE;
                    end
                end
                WRITE: begin
                    memz_we <= 1'b0;
                    i       <= i + 6'd1;
                    if (i == nz_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= CLEAR;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: reference convolution vs. Z writes.
module tb_conv_sequencer;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] size_x = '0;
    logic [LW-1:0] size_y = '0;
    logic [4:0]    memx_addr;
    logic [DW-1:0] memx_data = '0;
    logic [4:0]    memy_addr;
    logic [DW-1:0] memy_data = '0;
    logic [5:0]    memz_addr;
    logic [AW-1:0] memz_data;
    logic          memz_we;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [7:0] xmem [32];
    logic [7:0] ymem [32];

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];

    conv_sequencer #(
        .DATA_W(DW),
        .ACC_W (AW),
        .LEN_W (LW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .size_x   (size_x),
        .size_y   (size_y),
        .memx_addr(memx_addr),
        .memx_data(memx_data),
        .memy_addr(memy_addr),
        .memy_data(memy_data),
        .memz_addr(memz_addr),
        .memz_data(memz_data),
        .memz_we  (memz_we),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // One-cycle-latency read memories
    always @(posedge clk) begin
        memx_data <= xmem[memx_addr];
        memy_data <= ymem[memy_addr];
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every Z write must match the head of the expected queue
    always @(negedge clk) begin
        wr_t e;
        if (memz_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0d, none expected",
                         memz_addr, memz_data);
            end else begin
                e = exp_q.pop_front();
                chk("z_addr", int'(memz_addr), e.addr);
                chk("z_data", int'(memz_data), e.data);
            end
        end
    end

    task automatic model(int sx, int sy);
        for (int i = 0; i < sx + sy - 1; i++) begin
            int s;
            s = 0;
            for (int j = 0; j < sy; j++)
                if (i - j >= 0 && i - j < sx)
                    s += int'(xmem[i-j]) * int'(ymem[j]);
            exp_q.push_back('{i, s % 65536});
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 32; k++) begin
            xmem[k] = 8'($urandom);
            ymem[k] = 8'($urandom);
        end
    endtask

    task automatic run(int sx, int sy, bit poke);
        bit legal;
        int exp_cyc;
        int cyc;
        legal = sx >= 1 && sx <= 32 && sy >= 1 && sy <= 32;
        exp_cyc = legal ? (sx + sy - 1) * (2 * sy + 2) + 1 : 1;
        if (legal) model(sx, sy);
        @(negedge clk);
        start  = 1'b1;
        size_x = LW'(sx);
        size_y = LW'(sy);
        @(posedge clk);
        #1;
        start  = 1'b0;
        size_x = LW'($urandom);
        size_y = LW'($urandom);
        cyc = 1;
        while (!done && cyc < exp_cyc + 50) begin
            start = (poke && cyc == 3);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk("done_latency", cyc, exp_cyc);
        chk("err_flag", int'(err), int'(!legal));
        chk("busy_in_done", int'(busy), 1);
        chk("pending_writes", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("done_one_cycle", int'(done), 0);
        chk("busy_back_idle", int'(busy), 0);
    endtask

    task automatic check_outputs_zero(string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_we"}, int'(memz_we), 0);
        chk({tag, "_xaddr"}, int'(memx_addr), 0);
        chk({tag, "_yaddr"}, int'(memy_addr), 0);
        chk({tag, "_zaddr"}, int'(memz_addr), 0);
        chk({tag, "_zdata"}, int'(memz_data), 0);
    endtask

    task automatic abort_test();
        int cyc;
        int dcnt;
        fill_rand();
        model(3, 3);
        @(negedge clk);
        start  = 1'b1;
        size_x = 6'd3;
        size_y = 6'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        // Output i=2 begins at cycle 17 (CLEAR), MAC of tap 0 at cycle 19
        while (cyc < 19) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("abort");
        chk("abort_writes_seen", 5 - exp_q.size(), 2);
        exp_q.delete();
        rst_n = 1'b1;
        dcnt = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            xmem[k] = '0;
            ymem[k] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
        ymem[0] = 8'd1; ymem[1] = 8'd1;
        run(3, 2, 1'b0);

        xmem[0] = 8'd255;
        ymem[0] = 8'd255;
        run(1, 1, 1'b0);

        for (int k = 0; k < 32; k++) begin
            xmem[k] = 8'd255;
            ymem[k] = 8'd255;
        end
        run(32, 32, 1'b0);

        run(4, 0, 1'b0);
        run(0, 5, 1'b0);
        run(33, 2, 1'b0);
        fill_rand();
        run(2, 2, 1'b0);

        fill_rand();
        run(5, 3, 1'b1);

        abort_test();
        fill_rand();
        run(4, 3, 1'b0);

        for (int n = 0; n < 8; n++) begin
            fill_rand();
            run(int'($urandom_range(1, 32)), int'($urandom_range(1, 6)),
                1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
